// File: rtl/turn_controller_if.sv
// Move-bus bundle between the turn sequencer and its surroundings: player
// buttons, board state and game-over in; move strobe, cursor and status out.
interface turn_controller_if;
   logic        btn_next;
   logic        btn_ok;
   logic [17:0] board;
   logic        game_over;
   logic [3:0]  code;
   logic        sel;
   logic        pl;
   logic [3:0]  cursor;
   logic        reject;
   logic        timeout;
   logic        done;

   modport master (
      output btn_next, btn_ok, board, game_over,
      input  code, sel, pl, cursor, reject, timeout, done
   );

   modport slave (
      input  btn_next, btn_ok, board, game_over,
      output code, sel, pl, cursor, reject, timeout, done
   );
endinterface

// File: rtl/turn_controller.sv
// Tic-tac-toe turn sequencer: cursor/confirm handling, occupied-square rejection,
// per-turn timeout with auto-placement on the lowest empty square, and end of game.
module turn_controller #(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd500000000
) (
   input  logic              clk,
   input  logic              rst,
   turn_controller_if.slave  bus
);
   localparam logic [2:0] S_SELECT = 3'd0;
   localparam logic [2:0] S_COMMIT = 3'd1;
   localparam logic [2:0] S_SWITCH = 3'd2;
   localparam logic [2:0] S_DONE   = 3'd3;

   localparam logic [3:0]  CODE_NONE    = 4'hF;
   localparam logic [31:0] L_TIMER_LAST = TIMEOUT_CYCLES - 32'd1;

   logic [2:0]  r_state;
   logic [31:0] r_timer;
   logic [3:0]  r_cursor;
   logic [3:0]  r_code;
   logic        r_sel;
   logic        r_pl;
   logic        r_reject;
   logic        r_timeout;
   logic        r_done;

   // Padded to 16 so the 4-bit cursor can index it without range checks.
   logic [15:0] w_empty;
   logic        w_any_empty;
   logic        w_full;
   logic        w_cursor_empty;
   logic        w_timer_expired;
   logic [3:0]  w_lowest_empty;
   logic [3:0]  w_cursor_inc;

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_empty
         if (gi < 9) begin : g_cell
            assign w_empty[gi] = (bus.board[2*gi +: 2] == 2'b00);
         end else begin : g_pad
            assign w_empty[gi] = 1'b0;
         end
      end
   endgenerate

   assign w_any_empty     = |w_empty[8:0];
   assign w_full          = ~w_any_empty;
   assign w_cursor_empty  = w_empty[r_cursor];
   assign w_cursor_inc    = (r_cursor == 4'd8) ? 4'd0 : r_cursor + 4'd1;
   // >= rather than == so a reject landing on the last cycle only defers the timeout.
   assign w_timer_expired = (r_timer >= L_TIMER_LAST);

   always_comb begin
      w_lowest_empty = CODE_NONE;
      for (int i = 8; i >= 0; i--) begin
         if (w_empty[i]) begin
            w_lowest_empty = 4'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_SELECT;
         r_timer   <= 32'd0;
         r_cursor  <= 4'd0;
         r_code    <= CODE_NONE;
         r_sel     <= 1'b0;
         r_pl      <= 1'b0;
         r_reject  <= 1'b0;
         r_timeout <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_reject  <= 1'b0;
         r_timeout <= 1'b0;
         case (r_state)
            S_SELECT: begin
               if (bus.game_over) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else if (bus.btn_ok && w_cursor_empty) begin
                  r_code  <= r_cursor;
                  r_sel   <= 1'b1;
                  r_state <= S_COMMIT;
               end else if (bus.btn_ok) begin
                  r_reject <= 1'b1;
                  r_timer  <= r_timer + 32'd1;
                  if (bus.btn_next) begin
                     r_cursor <= w_cursor_inc;
                  end
               end else if (w_timer_expired) begin
                  if (w_any_empty) begin
                     r_code    <= w_lowest_empty;
                     r_sel     <= 1'b1;
                     r_timeout <= 1'b1;
                     r_state   <= S_COMMIT;
                  end else begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end else begin
                  r_timer <= r_timer + 32'd1;
                  if (bus.btn_next) begin
                     r_cursor <= w_cursor_inc;
                  end
               end
            end
            S_COMMIT: begin
               r_sel   <= 1'b0;
               r_code  <= CODE_NONE;
               r_state <= S_SWITCH;
            end
            S_SWITCH: begin
               r_pl    <= ~r_pl;
               r_timer <= 32'd0;
               if (bus.game_over || w_full) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= S_SELECT;
               end
            end
            S_DONE: begin
               r_sel  <= 1'b0;
               r_code <= CODE_NONE;
               r_done <= 1'b1;
            end
            default: begin
               r_state <= S_SELECT;
               r_sel   <= 1'b0;
               r_code  <= CODE_NONE;
               r_done  <= 1'b0;
               r_timer <= 32'd0;
            end
         endcase
      end
   end

   assign bus.code    = r_code;
   assign bus.sel     = r_sel;
   assign bus.pl      = r_pl;
   assign bus.cursor  = r_cursor;
   assign bus.reject  = r_reject;
   assign bus.timeout = r_timeout;
   assign bus.done    = r_done;
endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: reset, moves, rejection, timeout, cursor
// wrap/priority and both end-of-game paths, with a short per-turn timeout.
module tb_turn_controller;
   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic sel_seen;
   logic to_seen;

   turn_controller_if bus ();

   turn_controller #(.TIMEOUT_CYCLES(32'd20)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
      if (obs === exp) $display("[TB] %s ok (%0h)", tag, obs);
   endtask

   initial begin
      rst          = 1'b1;
      bus.btn_next = 1'b0;
      bus.btn_ok   = 1'b0;
      bus.board    = 18'd0;
      bus.game_over = 1'b0;

      // Asynchronous reset before any clock edge
      #2 rst = 1'b0;
      #1;
      chk("rst_sel",     {31'd0, bus.sel},     32'd0);
      chk("rst_code",    {28'd0, bus.code},    32'hF);
      chk("rst_cursor",  {28'd0, bus.cursor},  32'd0);
      chk("rst_pl",      {31'd0, bus.pl},      32'd0);
      chk("rst_done",    {31'd0, bus.done},    32'd0);
      chk("rst_reject",  {31'd0, bus.reject},  32'd0);
      chk("rst_timeout", {31'd0, bus.timeout}, 32'd0);
      repeat (2) tick();
      rst = 1'b1;

      // Basic move on square 3
      bus.btn_next = 1'b1;
      repeat (3) tick();
      bus.btn_next = 1'b0;
      chk("basic_cursor3", {28'd0, bus.cursor}, 32'd3);
      bus.btn_ok = 1'b1;
      tick();
      bus.btn_ok = 1'b0;
      chk("basic_sel", {31'd0, bus.sel},  32'd1);
      chk("basic_code", {28'd0, bus.code}, 32'd3);
      chk("basic_pl",  {31'd0, bus.pl},   32'd0);
      tick();
      bus.board[7:6] = 2'b01;
      chk("basic_sel_once", {31'd0, bus.sel},  32'd0);
      chk("basic_code_idle", {28'd0, bus.code}, 32'hF);
      tick();
      chk("basic_pl_toggle", {31'd0, bus.pl},     32'd1);
      chk("basic_cursor_kept", {28'd0, bus.cursor}, 32'd3);

      // Confirm on occupied square 3
      bus.btn_ok = 1'b1;
      tick();
      bus.btn_ok = 1'b0;
      chk("occ_reject", {31'd0, bus.reject}, 32'd1);
      chk("occ_sel",    {31'd0, bus.sel},    32'd0);
      chk("occ_pl",     {31'd0, bus.pl},     32'd1);
      tick();
      chk("occ_reject_pulse", {31'd0, bus.reject}, 32'd0);

      // Cursor wrap and btn_ok/btn_next priority
      bus.btn_next = 1'b1;
      repeat (5) tick();
      chk("wrap_cursor8", {28'd0, bus.cursor}, 32'd8);
      tick();
      chk("wrap_cursor0", {28'd0, bus.cursor}, 32'd0);
      repeat (5) tick();
      chk("prio_cursor5", {28'd0, bus.cursor}, 32'd5);
      bus.btn_ok = 1'b1;
      tick();
      bus.btn_ok   = 1'b0;
      bus.btn_next = 1'b0;
      chk("prio_sel",    {31'd0, bus.sel},    32'd1);
      chk("prio_code",   {28'd0, bus.code},   32'd5);
      chk("prio_cursor", {28'd0, bus.cursor}, 32'd5);
      tick();
      bus.board[11:10] = 2'b10;
      tick();
      chk("prio_pl_back", {31'd0, bus.pl}, 32'd0);

      // Timeout with squares 0 and 1 occupied
      bus.board[1:0] = 2'b01;
      bus.board[3:2] = 2'b10;
      repeat (19) tick();
      chk("to_not_yet", {31'd0, bus.timeout}, 32'd0);
      chk("to_no_sel",  {31'd0, bus.sel},     32'd0);
      tick();
      chk("to_pulse", {31'd0, bus.timeout}, 32'd1);
      chk("to_sel",   {31'd0, bus.sel},     32'd1);
      chk("to_code",  {28'd0, bus.code},    32'd2);
      chk("to_pl",    {31'd0, bus.pl},      32'd0);
      tick();
      bus.board[5:4] = 2'b01;
      chk("to_pulse_end", {31'd0, bus.timeout}, 32'd0);
      tick();
      chk("to_pl_toggle", {31'd0, bus.pl}, 32'd1);

      // game_over in SELECT, then nothing gets through
      bus.game_over = 1'b1;
      tick();
      bus.game_over = 1'b0;
      chk("go_done", {31'd0, bus.done}, 32'd1);
      sel_seen = 1'b0;
      to_seen  = 1'b0;
      for (int i = 0; i < 30; i++) begin
         bus.btn_ok   = i[0];
         bus.btn_next = ~i[0];
         tick();
         sel_seen = sel_seen | bus.sel;
         to_seen  = to_seen | bus.timeout;
      end
      bus.btn_ok   = 1'b0;
      bus.btn_next = 1'b0;
      chk("go_no_sel",     {31'd0, sel_seen}, 32'd0);
      chk("go_no_timeout", {31'd0, to_seen},  32'd0);
      chk("go_done_held",  {31'd0, bus.done}, 32'd1);

      // Reset in the middle of a COMMIT
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      rst = 1'b1;
      bus.board = 18'd0;
      bus.btn_next = 1'b1;
      tick();
      bus.btn_next = 1'b0;
      bus.btn_ok = 1'b1;
      tick();
      bus.btn_ok = 1'b0;
      chk("mid_commit_sel", {31'd0, bus.sel}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_sel",    {31'd0, bus.sel},    32'd0);
      chk("mid_rst_code",   {28'd0, bus.code},   32'hF);
      chk("mid_rst_cursor", {28'd0, bus.cursor}, 32'd0);
      chk("mid_rst_pl",     {31'd0, bus.pl},     32'd0);
      chk("mid_rst_done",   {31'd0, bus.done},   32'd0);
      tick();
      bus.board = 18'd0;
      rst = 1'b1;

      // Nine alternating moves fill the board
      for (int k = 0; k < 9; k++) begin
         if (k > 0) begin
            bus.btn_next = 1'b1;
            tick();
            bus.btn_next = 1'b0;
         end
         bus.btn_ok = 1'b1;
         tick();
         bus.btn_ok = 1'b0;
         chk($sformatf("fill%0d_sel", k),  {31'd0, bus.sel},  32'd1);
         chk($sformatf("fill%0d_code", k), {28'd0, bus.code}, 32'(k));
         chk($sformatf("fill%0d_pl", k),   {31'd0, bus.pl},   32'(k % 2));
         tick();
         bus.board[2*k +: 2] = (k % 2 == 1) ? 2'b10 : 2'b01;
         tick();
         chk($sformatf("fill%0d_done", k), {31'd0, bus.done}, (k == 8) ? 32'd1 : 32'd0);
      end
      bus.btn_ok = 1'b1;
      tick();
      bus.btn_ok = 1'b0;
      chk("full_no_sel", {31'd0, bus.sel}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
